hazard_sequencer: RTL and testbench

- Pipeline control block for the 5-stage MIPS core; works alongside the forwarding unit.
- Covers the hazards forwarding cannot resolve:
  - load-use stalls, with a programmable number of bubbles;
  - branch/jump flushes;
  - data-memory wait freezes;
  - post-reset pipeline drain.
- Drives the PC, IF/ID and ID/EX write-enable, flush and bubble controls.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/hazard_detect.sv | 24 ++
 rtl/hazard_sequencer.sv | 159 +++++++++++++++
 tb/tb_hazard_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions for the 5-stage MIPS core.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    DRAIN    = 2'd0,
    RUN      = 2'd1,
    LU_STALL = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  localparam int          REG_W     = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detection: load-use hazard and data-memory stall.
// Kept standalone so the forwarding-unit bench can reuse it.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             lu_hazard,
  output logic             mem_stall
);

  // $0 is hardwired to zero, so a load targeting it never creates a hazard.
  always_comb begin
    lu_hazard = id_ex_mem_read && (id_ex_rt != '0) &&
                ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
    mem_stall = dmem_req && !dmem_ready;
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: post-reset drain, load-use bubbles, branch
// flushes and data-memory freezes. Outputs are combinational from the
// registered state and act in the current cycle.
// Optional macro HAZARD_PERF_CNT_EN adds saturating performance counters.
module hazard_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int LU_BUBBLES   = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic [1:0]       state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int BW = 2;

  if (LU_BUBBLES < 1 || LU_BUBBLES > 3 || DRAIN_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
    $error("hazard_sequencer: parameter out of range");
  end

  state_t        state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_nxt;
  logic [BW-1:0] bub_cnt, bub_nxt;
  logic          lu_hazard, mem_stall;
  logic          lu_act, flush_act;

  hazard_detect u_detect (
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rt       (id_ex_rt),
    .if_id_rs       (if_id_rs),
    .if_id_rt       (if_id_rt),
    .if_id_uses_rt  (if_id_uses_rt),
    .dmem_req       (dmem_req),
    .dmem_ready     (dmem_ready),
    .lu_hazard      (lu_hazard),
    .mem_stall      (mem_stall)
  );

  assign state_o = state;

  // State and counter registers; reset re-enters DRAIN and clears counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= DRAIN;
      drain_cnt <= DW'(DRAIN_CYCLES - 1);
      bub_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      bub_cnt   <= bub_nxt;
    end
  end

  // Next state and control outputs; reset overrides everything last.
  always_comb begin
    state_nxt    = state;
    drain_nxt    = drain_cnt;
    bub_nxt      = bub_cnt;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    lu_act       = 1'b0;
    flush_act    = 1'b0;
    case (state)
      DRAIN: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        if (drain_cnt == '0) state_nxt = RUN;
        else                 drain_nxt = drain_cnt - 1'b1;
      end
      RUN: begin
        if (mem_stall) begin
          pipe_freeze = 1'b1;
          state_nxt   = MEM_WAIT;
        end else if (lu_hazard) begin
          // A coincident branch is dropped; ID re-resolves it after the stall.
          id_ex_bubble = 1'b1;
          lu_act       = 1'b1;
          if (LU_BUBBLES > 1) begin
            state_nxt = LU_STALL;
            bub_nxt   = BW'(LU_BUBBLES - 2);
          end
        end else if (branch_taken) begin
          if_id_flush = 1'b1;
          pc_write    = 1'b1;
          flush_act   = 1'b1;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end
      LU_STALL: begin
        if (mem_stall) begin
          // Freeze wins this cycle; the remaining bubble count is held.
          pipe_freeze = 1'b1;
        end else begin
          id_ex_bubble = 1'b1;
          lu_act       = 1'b1;
          if (bub_cnt == '0) state_nxt = RUN;
          else               bub_nxt   = bub_cnt - 1'b1;
        end
      end
      MEM_WAIT: begin
        pipe_freeze = 1'b1;
        if (dmem_ready) state_nxt = RUN;
      end
      default: state_nxt = DRAIN;
    endcase
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      pipe_freeze  = 1'b0;
      lu_act       = 1'b0;
      flush_act    = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters; drain flushes/bubbles are not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      lu_stall_cnt  <= '0;
      mem_stall_cnt <= '0;
      flush_cnt     <= '0;
    end else begin
      if (lu_act && lu_stall_cnt != '1)      lu_stall_cnt  <= lu_stall_cnt + 1'b1;
      if (pipe_freeze && mem_stall_cnt != '1) mem_stall_cnt <= mem_stall_cnt + 1'b1;
      if (flush_act && flush_cnt != '1)       flush_cnt     <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer; two instances cover LU_BUBBLES=1 and 3.
module tb_hazard_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_ex_mem_read;
  logic [4:0] id_ex_rt, if_id_rs, if_id_rt;
  logic       if_id_uses_rt, branch_taken, dmem_req, dmem_ready;

  logic       p1_pc, p1_ifw, p1_flush, p1_bub, p1_frz;
  logic [1:0] p1_st;
  logic       p3_pc, p3_ifw, p3_flush, p3_bub, p3_frz;
  logic [1:0] p3_st;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] p1_luc, p1_msc, p1_flc, p3_luc, p3_msc, p3_flc;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(.DRAIN_CYCLES(4), .LU_BUBBLES(1), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(p1_pc), .if_id_write(p1_ifw), .if_id_flush(p1_flush),
    .id_ex_bubble(p1_bub), .pipe_freeze(p1_frz), .state_o(p1_st)
`ifdef HAZARD_PERF_CNT_EN
    , .lu_stall_cnt(p1_luc), .mem_stall_cnt(p1_msc), .flush_cnt(p1_flc)
`endif
  );

  hazard_sequencer #(.DRAIN_CYCLES(4), .LU_BUBBLES(3), .CNT_W(32)) dut3 (
    .clk(clk), .reset(reset), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(p3_pc), .if_id_write(p3_ifw), .if_id_flush(p3_flush),
    .id_ex_bubble(p3_bub), .pipe_freeze(p3_frz), .state_o(p3_st)
`ifdef HAZARD_PERF_CNT_EN
    , .lu_stall_cnt(p3_luc), .mem_stall_cnt(p3_msc), .flush_cnt(p3_flc)
`endif
  );

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_ex_mem_read = 0; id_ex_rt = 0; if_id_rs = 0; if_id_rt = 0;
    if_id_uses_rt = 0; branch_taken = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  // lw $2 in EX, add $3,$2,$4 in ID
  task automatic set_lu();
    id_ex_mem_read = 1; id_ex_rt = 5'd2; if_id_rs = 5'd2; if_id_rt = 5'd4; if_id_uses_rt = 1;
  endtask

  // Drain after reset release: 4 flush cycles, RUN on the 5th.
  task automatic check_drain(string tag);
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (p1_flush !== 1'b1 || p1_pc !== 1'b0 || p1_st !== 2'd0 || p3_st !== 2'd0) begin
        errors++;
        $display("FAIL %s_drain_c%0d: flush=%b pc=%b st1=%0d st3=%0d, need flush=1 pc=0 st=0",
                 tag, i, p1_flush, p1_pc, p1_st, p3_st);
      end
      step();
    end
    checks++;
    if (p1_st !== 2'd1 || p3_st !== 2'd1 || p1_pc !== 1'b1 || p1_flush !== 1'b0) begin
      errors++;
      $display("FAIL %s_run: st1=%0d st3=%0d pc=%b flush=%b, need st=1 pc=1 flush=0",
               tag, p1_st, p3_st, p1_pc, p1_flush);
    end
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    step(); step();
    checks++;
    if (p1_st !== 2'd0 || p1_pc !== 0 || p1_ifw !== 0 || p1_flush !== 1 || p1_bub !== 1 || p1_frz !== 0) begin
      errors++;
      $display("FAIL reset_outputs: st=%0d pc=%b ifw=%b flush=%b bub=%b frz=%b, need 0 0 0 1 1 0",
               p1_st, p1_pc, p1_ifw, p1_flush, p1_bub, p1_frz);
    end
    reset = 0;
    check_drain("reset");
  endtask

  task automatic test_load_use();
    int n1, n3;
    n1 = 0; n3 = 0;
    set_lu();
    #1;
    checks++;
    if (p1_pc !== 0 || p1_ifw !== 0 || p1_bub !== 1 || p1_flush !== 0) begin
      errors++;
      $display("FAIL lu_first: pc=%b ifw=%b bub=%b flush=%b, need 0 0 1 0", p1_pc, p1_ifw, p1_bub, p1_flush);
    end
    for (int i = 0; i < 5; i++) begin
      if (p1_bub === 1'b1) n1++;
      if (p3_bub === 1'b1 && p3_pc === 1'b0) n3++;
      step();
      idle();
      #1;
      if (i == 0) begin
        checks++;
        if (p1_pc !== 1 || p1_st !== 2'd1 || p3_st !== 2'd2 || p3_pc !== 0) begin
          errors++;
          $display("FAIL lu_after1: pc1=%b st1=%0d st3=%0d pc3=%b, need 1 1 2 0", p1_pc, p1_st, p3_st, p3_pc);
        end
      end
    end
    checks++;
    if (n1 != 1) begin errors++; $display("FAIL lu_count_b1: got %0d bubbles, need 1", n1); end
    checks++;
    if (n3 != 3) begin errors++; $display("FAIL lu_count_b3: got %0d bubbles, need 3", n3); end
    checks++;
    if (p3_st !== 2'd1 || p3_pc !== 1) begin
      errors++;
      $display("FAIL lu_resume_b3: st=%0d pc=%b, need 1 1", p3_st, p3_pc);
    end
  endtask

  task automatic test_rt_match();
    id_ex_mem_read = 1; id_ex_rt = 5'd7; if_id_rs = 5'd1; if_id_rt = 5'd7; if_id_uses_rt = 0;
    #1;
    checks++;
    if (p1_pc !== 1 || p1_bub !== 0) begin
      errors++;
      $display("FAIL rt_unused: pc=%b bub=%b, need 1 0", p1_pc, p1_bub);
    end
    if_id_uses_rt = 1;
    #1;
    checks++;
    if (p1_pc !== 0 || p1_bub !== 1) begin
      errors++;
      $display("FAIL rt_used: pc=%b bub=%b, need 0 1", p1_pc, p1_bub);
    end
    step(); idle(); step(); step(); step();
  endtask

  task automatic test_zero_reg();
    id_ex_mem_read = 1; id_ex_rt = 5'd0; if_id_rs = 5'd0; if_id_rt = 5'd0; if_id_uses_rt = 1;
    #1;
    checks++;
    if (p1_pc !== 1 || p1_bub !== 0 || p3_pc !== 1) begin
      errors++;
      $display("FAIL zero_reg: pc1=%b bub1=%b pc3=%b, need 1 0 1", p1_pc, p1_bub, p3_pc);
    end
    step();
    checks++;
    if (p3_st !== 2'd1 || p3_pc !== 1) begin
      errors++;
      $display("FAIL zero_reg_next: st3=%0d pc3=%b, need 1 1", p3_st, p3_pc);
    end
    idle();
  endtask

  task automatic test_mem_wait();
    int nf;
    bit bad;
    nf = 0; bad = 0;
    for (int i = 0; i < 8; i++) begin
      dmem_req   = (i < 6);
      dmem_ready = (i == 5);
      if (i >= 1 && i <= 4) begin set_lu(); branch_taken = 1; end
      else begin id_ex_mem_read = 0; branch_taken = 0; end
      #1;
      if (p1_frz === 1'b1) nf++;
      if (p1_frz === 1'b1 && (p1_pc !== 0 || p1_ifw !== 0 || p1_flush !== 0 || p1_bub !== 0)) bad = 1;
      if (p3_frz === 1'b1 && (p3_pc !== 0 || p3_flush !== 0 || p3_bub !== 0)) bad = 1;
      if (i == 1) begin
        checks++;
        if (p1_st !== 2'd3 || p3_st !== 2'd3) begin
          errors++;
          $display("FAIL mem_state: st1=%0d st3=%0d, need 3", p1_st, p3_st);
        end
      end
      if (i == 6) begin
        checks++;
        if (p1_st !== 2'd1 || p1_pc !== 1 || p1_frz !== 0 || p3_st !== 2'd1) begin
          errors++;
          $display("FAIL mem_resume: st1=%0d pc=%b frz=%b st3=%0d, need 1 1 0 1", p1_st, p1_pc, p1_frz, p3_st);
        end
      end
      step();
    end
    idle();
    checks++;
    if (nf != 6) begin errors++; $display("FAIL mem_freeze_count: got %0d cycles, need 6", nf); end
    checks++;
    if (bad) begin errors++; $display("FAIL mem_ignore: hazard/branch leaked during freeze, need none"); end
  endtask

  task automatic test_branch();
    branch_taken = 1;
    #1;
    checks++;
    if (p1_flush !== 1 || p1_pc !== 1 || p1_bub !== 0 || p1_frz !== 0) begin
      errors++;
      $display("FAIL branch: flush=%b pc=%b bub=%b frz=%b, need 1 1 0 0", p1_flush, p1_pc, p1_bub, p1_frz);
    end
    step();
    branch_taken = 0;
    #1;
    checks++;
    if (p1_flush !== 0 || p1_pc !== 1 || p1_st !== 2'd1) begin
      errors++;
      $display("FAIL branch_once: flush=%b pc=%b st=%0d, need 0 1 1", p1_flush, p1_pc, p1_st);
    end
    branch_taken = 1;
    set_lu();
    #1;
    checks++;
    if (p1_flush !== 0 || p1_bub !== 1 || p1_pc !== 0) begin
      errors++;
      $display("FAIL branch_lu: flush=%b bub=%b pc=%b, need 0 1 0", p1_flush, p1_bub, p1_pc);
    end
    step(); idle(); step(); step(); step();
  endtask

  task automatic test_reset_mid_stall();
    set_lu();
    step();
    idle();
    #1;
    checks++;
    if (p3_st !== 2'd2) begin errors++; $display("FAIL mid_setup: st3=%0d, need 2", p3_st); end
    reset = 1;
    #1;
    checks++;
    if (p3_flush !== 1 || p3_pc !== 0 || p3_bub !== 1 || p3_frz !== 0) begin
      errors++;
      $display("FAIL mid_force: flush=%b pc=%b bub=%b frz=%b, need 1 0 1 0", p3_flush, p3_pc, p3_bub, p3_frz);
    end
    step();
    checks++;
    if (p3_st !== 2'd0 || p1_st !== 2'd0) begin
      errors++;
      $display("FAIL mid_state: st1=%0d st3=%0d, need 0", p1_st, p3_st);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (p3_luc !== 0 || p3_msc !== 0 || p3_flc !== 0 || p1_luc !== 0 || p1_msc !== 0 || p1_flc !== 0) begin
      errors++;
      $display("FAIL mid_counters: lu=%0d mem=%0d fl=%0d, need 0", p3_luc, p3_msc, p3_flc);
    end
`endif
    reset = 0;
    check_drain("mid");
    step();
    set_lu();
    step();
    idle();
    #1;
    checks++;
    if (p3_st !== 2'd2 || p3_bub !== 1) begin
      errors++;
      $display("FAIL mid_restall: st3=%0d bub=%b, need 2 1", p3_st, p3_bub);
    end
    step();
    checks++;
    if (p3_st !== 2'd2 || p3_bub !== 1) begin
      errors++;
      $display("FAIL mid_restall2: st3=%0d bub=%b, need 2 1", p3_st, p3_bub);
    end
    step();
    checks++;
    if (p3_st !== 2'd1 || p3_pc !== 1) begin
      errors++;
      $display("FAIL mid_reexit: st3=%0d pc=%b, need 1 1", p3_st, p3_pc);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (p1_luc !== 1 || p3_luc !== 3) begin
      errors++;
      $display("FAIL perf_lu: cnt1=%0d cnt3=%0d, need 1 3", p1_luc, p3_luc);
    end
`endif
  endtask

  initial begin
    idle();
    reset = 1;
    #1;
    test_reset();
    test_load_use();
    test_rt_match();
    test_zero_reg();
    test_mem_wait();
    test_branch();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
